// File: rtl/tx_level_hold.sv
// tx_level_hold: drives a level output that holds each new level for at least HOLD_CNT cycles
module tx_level_hold #(
    parameter int       HOLD_CNT = 3,
    parameter bit [0:0] INIT_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic signal_out,
    output logic edge_pulse,
    output logic busy
);
    localparam int HW = $clog2(HOLD_CNT) + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_lvl_q, pend_lvl_d;
    logic          out_q, out_d;
    logic          edge_q, edge_d;
    logic          hs, dec, cand_vld, cand_lvl;

    assign req_ready  = !pend_vld_q;
    assign hs         = req_valid && req_ready;
    assign dec        = (state_q == IDLE) || (hcnt_q == HW'(HOLD_CNT - 1));
    assign cand_vld   = pend_vld_q || hs;
    assign cand_lvl   = pend_vld_q ? pend_lvl_q : req_level;
    assign signal_out = out_q;
    assign edge_pulse = edge_q;
    assign busy       = (state_q == HOLD);

    // decide the next level at IDLE/expiry, otherwise count the hold and buffer requests
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        pend_vld_d = pend_vld_q;
        pend_lvl_d = pend_lvl_q;
        out_d      = out_q;
        edge_d     = 1'b0;
        if (dec) begin
            state_d    = IDLE;
            hcnt_d     = '0;
            pend_vld_d = pend_vld_q && hs;
            pend_lvl_d = (pend_vld_q && hs) ? req_level : pend_lvl_q;
            if (cand_vld && (cand_lvl != out_q)) begin
                out_d   = cand_lvl;
                edge_d  = 1'b1;
                state_d = HOLD;
            end
        end else begin
            hcnt_d = hcnt_q + 1'b1;
            if (hs) begin
                pend_vld_d = 1'b1;
                pend_lvl_d = req_level;
            end
        end
    end

    // state registers; reset drops any pending entry and the running hold at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_lvl_q <= 1'b0;
            out_q      <= INIT_LVL;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            pend_vld_q <= pend_vld_d;
            pend_lvl_q <= pend_lvl_d;
            out_q      <= out_d;
            edge_q     <= edge_d;
        end
    end
endmodule

// File: tb/tb_tx_level_hold.sv
// tb_tx_level_hold: directed checks of tx_level_hold with HOLD_CNT=3 and HOLD_CNT=1
module tb_tx_level_hold;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v = 1'b0, l = 1'b0, rdy, out, edg, bsy;
    logic v1 = 1'b0, l1 = 1'b0, rdy1, out1, edg1, bsy1;
    int checks = 0;
    int errors = 0;

    tx_level_hold #(.HOLD_CNT(3), .INIT_LVL(1'b0)) dut (
        .clk(clk), .rst(rst), .req_valid(v), .req_level(l),
        .req_ready(rdy), .signal_out(out), .edge_pulse(edg), .busy(bsy)
    );

    tx_level_hold #(.HOLD_CNT(1), .INIT_LVL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_level(l1),
        .req_ready(rdy1), .signal_out(out1), .edge_pulse(edg1), .busy(bsy1)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #3;
        chk("rst_out", out, 1'b0);
        chk("rst_edge", edg, 1'b0);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_ready", rdy, 1'b1);
        step(); step();
        rst = 1'b1;
        // redundant request: level 0 while output is 0
        v = 1'b1; l = 1'b0;
        step();
        chk("red_out", out, 1'b0);
        chk("red_edge", edg, 1'b0);
        chk("red_busy", bsy, 1'b0);
        chk("red_ready", rdy, 1'b1);
        v = 1'b0;
        step();
        chk("red_busy2", bsy, 1'b0);
        // single request: level 1, three busy cycles
        v = 1'b1; l = 1'b1;
        step();
        chk("sgl_out_e0", out, 1'b1);
        chk("sgl_edge_e0", edg, 1'b1);
        chk("sgl_busy_e0", bsy, 1'b1);
        v = 1'b0;
        step();
        chk("sgl_edge_e1", edg, 1'b0);
        chk("sgl_busy_e1", bsy, 1'b1);
        step();
        chk("sgl_busy_e2", bsy, 1'b1);
        step();
        chk("sgl_busy_e3", bsy, 1'b0);
        chk("sgl_out_e3", out, 1'b1);
        // back-to-back 1,0,1
        do_reset();
        v = 1'b1; l = 1'b1;
        step();
        chk("b2b_out_e0", out, 1'b1);
        chk("b2b_edge_e0", edg, 1'b1);
        chk("b2b_ready_e0", rdy, 1'b1);
        l = 1'b0;
        step();
        chk("b2b_ready_e1", rdy, 1'b0);
        chk("b2b_out_e1", out, 1'b1);
        l = 1'b1;
        step();
        chk("b2b_ready_e2", rdy, 1'b0);
        chk("b2b_out_e2", out, 1'b1);
        chk("b2b_edge_e2", edg, 1'b0);
        step();
        chk("b2b_out_e3", out, 1'b0);
        chk("b2b_edge_e3", edg, 1'b1);
        chk("b2b_ready_e3", rdy, 1'b1);
        step();
        chk("b2b_ready_e4", rdy, 1'b0);
        chk("b2b_out_e4", out, 1'b0);
        v = 1'b0;
        step();
        chk("b2b_out_e5", out, 1'b0);
        chk("b2b_edge_e5", edg, 1'b0);
        step();
        chk("b2b_out_e6", out, 1'b1);
        chk("b2b_edge_e6", edg, 1'b1);
        chk("b2b_ready_e6", rdy, 1'b1);
        step(); step(); step();
        chk("b2b_idle_e9", bsy, 1'b0);
        // pending entry equal to current level is dropped at expiry
        do_reset();
        v = 1'b1; l = 1'b1;
        step();
        chk("peq_out_e0", out, 1'b1);
        step();
        chk("peq_ready_e1", rdy, 1'b0);
        v = 1'b0;
        step();
        chk("peq_busy_e2", bsy, 1'b1);
        step();
        chk("peq_edge_e3", edg, 1'b0);
        chk("peq_busy_e3", bsy, 1'b0);
        chk("peq_ready_e3", rdy, 1'b1);
        chk("peq_out_e3", out, 1'b1);
        // reset mid-hold with a pending entry
        do_reset();
        v = 1'b1; l = 1'b1;
        step();
        chk("mrs_out_e0", out, 1'b1);
        l = 1'b0;
        step();
        chk("mrs_ready_e1", rdy, 1'b0);
        v = 1'b0;
        rst = 1'b0;
        #2;
        chk("mrs_out_async", out, 1'b0);
        chk("mrs_ready_async", rdy, 1'b1);
        chk("mrs_busy_async", bsy, 1'b0);
        chk("mrs_edge_async", edg, 1'b0);
        step();
        chk("mrs_out_held", out, 1'b0);
        rst = 1'b1;
        v = 1'b1; l = 1'b1;
        step();
        chk("post_out", out, 1'b1);
        chk("post_edge", edg, 1'b1);
        chk("post_busy", bsy, 1'b1);
        v = 1'b0;
        // HOLD_CNT=1: a change every cycle
        v1 = 1'b1; l1 = 1'b1;
        step();
        chk("h1_out_0", out1, 1'b1);
        chk("h1_edge_0", edg1, 1'b1);
        l1 = 1'b0;
        step();
        chk("h1_out_1", out1, 1'b0);
        chk("h1_edge_1", edg1, 1'b1);
        l1 = 1'b1;
        step();
        chk("h1_out_2", out1, 1'b1);
        chk("h1_edge_2", edg1, 1'b1);
        l1 = 1'b0;
        step();
        chk("h1_out_3", out1, 1'b0);
        chk("h1_edge_3", edg1, 1'b1);
        v1 = 1'b0;
        step();
        chk("h1_out_4", out1, 1'b0);
        chk("h1_edge_4", edg1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
